multitrack_rec_ctrl: RTL and testbench
======================================

// Module: multitrack_rec_ctrl
// PURPOSE
//  Top-level recorder/player sequencer for the WM8731 audio path; replaces the single-buffer control FSM.
//  Splits SRAM into NUM_TRACKS equal partitions and tracks the recorded length of each.
//  Drives one-cycle start/pause/stop pulses to the recorder and DSP, and auto-stops at partition-full or end-of-track.
//  Sits between the key inputs and the I2C initialiser / AudRecorder / AudDSP / AudPlayer blocks.
// PARAMETERS
//  ADDR_W      20    SRAM word-address width
//  NUM_TRACKS  4     number of partitions; power of 2, >=2; TRK_W = $clog2(NUM_TRACKS)
//  INIT_HOLD   2048  cycles o_init_start is held high after reset release
//  PART_SIZE (local) = 2**ADDR_W / NUM_TRACKS words per partition
// PORTS
//  i_clk          in   1       system clock
//  i_rst_n        in   1       async active-low reset
//  i_key_rec      in   1       record/pause-record key; single-cycle pulse, already debounced
//  i_key_play     in   1       play/pause-play key; single-cycle pulse
//  i_key_stop     in   1       stop key; single-cycle pulse
//  i_track_sel    in   TRK_W   track chosen for the next record or play
//  i_init_done    in   1       I2C initialiser finished (level)
//  i_rec_addr     in   ADDR_W  recorder next-write address
//  i_play_addr    in   ADDR_W  DSP current fetch address
//  o_init_start   out  1       I2C initialiser start
//  o_rec_start    out  1       recorder start/resume pulse
//  o_rec_pause    out  1       recorder pause pulse
//  o_rec_stop     out  1       recorder stop pulse
//  o_play_start   out  1       DSP start/resume pulse
//  o_play_pause   out  1       DSP pause pulse
//  o_play_stop    out  1       DSP stop pulse
//  o_play_en      out  1       AudPlayer enable (level)
//  o_sram_wr      out  1       recorder owns SRAM; drives WE_N/DQ muxing
//  o_base_addr    out  ADDR_W  active-track base = trk*PART_SIZE
//  o_state        out  3       current state encoding
// BEHAVIOUR
//  - Reset values:
//    - state = INIT; all outputs 0.
//    - All track lengths = 0.
//    - Latched track register = 0.
//    - Init counter = 0.
//  - Reset mid-operation aborts immediately. No stop pulse is issued.
//  - States: INIT=0, IDLE=1, RECD=2, RECD_PAUSE=3, PLAY=4, PLAY_PAUSE=5. Codes 6 and 7 recover to IDLE.
//  - All outputs are registered. A pulse is high for exactly 1 cycle, the cycle after the key is sampled.
//  - Key priority in the same cycle: stop > rec > play.
//  - INIT:
//    - o_init_start is high for cycles 1..INIT_HOLD after reset release, then low.
//    - Go to IDLE when i_init_done=1. i_init_done may arrive before INIT_HOLD expires.
//    - All keys are ignored in INIT.
//  - IDLE:
//    - rec -> RECD. Latch i_track_sel; pulse o_rec_start.
//    - play -> PLAY only if len[i_track_sel]!=0. Latch track; pulse o_play_start; o_play_en=1.
//    - play with len=0 is ignored.
//    - stop is ignored.
//  - i_track_sel is ignored outside IDLE.
//  - RECD:
//    - rec -> RECD_PAUSE with o_rec_pause.
//    - stop -> IDLE with o_rec_stop; len[trk] <= i_rec_addr - o_base_addr (ADDR_W modulo arithmetic).
//  - RECD_PAUSE:
//    - rec -> RECD with o_rec_start.
//    - stop behaves as in RECD.
//  - Partition full: in RECD, when offset = i_rec_addr - base >= PART_SIZE-1:
//    - Pulse o_rec_stop.
//    - len[trk] <= PART_SIZE-1.
//    - Go to IDLE.
//    - Same-cycle stop key gives an identical result.
//  - PLAY:
//    - play -> PLAY_PAUSE with o_play_pause; o_play_en=0.
//    - stop -> IDLE with o_play_stop; o_play_en=0.
//  - PLAY_PAUSE:
//    - play -> PLAY with o_play_start; o_play_en=1.
//    - stop -> IDLE with o_play_stop.
//  - End of track: in PLAY, when i_play_addr - base >= len[trk]:
//    - Pulse o_play_stop.
//    - Further action per CONFIGURATION.
//    - rec keys are ignored in PLAY and PLAY_PAUSE.
//  - o_sram_wr=1 only in RECD. o_base_addr is always valid from the latched track.
//  - Re-recording a track overwrites its length. Other tracks are untouched.
// CONFIGURATION
//  - LOOP_PLAY_EN undefined: end of track -> o_play_stop, o_play_en=0, state IDLE.
//  - LOOP_PLAY_EN defined: end of track -> o_play_stop, then o_play_start the next cycle.
//    - State stays PLAY; o_play_en stays 1.
//    - The end condition is not re-evaluated during those 2 cycles.
//    - A stop key in either cycle wins: go to IDLE with no o_play_start.
// TESTING
//  T1: reset; i_init_done at cycle 10 -> o_init_start high cycles 1..2048; o_state 0->1 at cycle 11.
//  T2: track 2, rec; stop with i_rec_addr=0x80100 -> o_rec_start; o_base_addr=0x80000; o_sram_wr=1; len[2]=0x100; IDLE.
//  T3: track 1, rec; i_rec_addr reaches 0x7FFFF -> o_rec_stop auto; len[1]=0x3FFFF; IDLE.
//  T4: play track 3 with len=0 -> stays IDLE, no pulses. Play track 2; i_play_addr=0x80100 -> o_play_stop, IDLE (no macro).
//  T5: LOOP_PLAY_EN; play track 2 to end -> o_play_stop, then o_play_start next cycle; o_play_en stays 1.
//  T6: rec+stop in same cycle in RECD -> stop wins. Reset during PLAY -> INIT, all outputs 0, all lengths 0.

Source files
------------

// File: rtl/multitrack_rec_ctrl.sv
// Multi-track record/play sequencer: partitions SRAM into NUM_TRACKS slices and tracks each slice's length.
// Optional LOOP_PLAY_EN: at end of track, restart playback instead of returning to idle.
module multitrack_rec_ctrl #(
  parameter int ADDR_W     = 20,
  parameter int NUM_TRACKS = 4,
  parameter int INIT_HOLD  = 2048,
  localparam int TRK_W     = $clog2(NUM_TRACKS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_rec,
  input  logic              i_key_play,
  input  logic              i_key_stop,
  input  logic [TRK_W-1:0]  i_track_sel,
  input  logic              i_init_done,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic              o_init_start,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_play_start,
  output logic              o_play_pause,
  output logic              o_play_stop,
  output logic              o_play_en,
  output logic              o_sram_wr,
  output logic [ADDR_W-1:0] o_base_addr,
  output logic [2:0]        o_state
);
  localparam int OFF_W = ADDR_W - TRK_W;
  localparam logic [ADDR_W-1:0] PART_MAX = ADDR_W'((2 ** OFF_W) - 1);
  localparam int CNT_W = $clog2(INIT_HOLD + 1);

  typedef enum logic [2:0] {
    S_INIT       = 3'd0,
    S_IDLE       = 3'd1,
    S_RECD       = 3'd2,
    S_RECD_PAUSE = 3'd3,
    S_PLAY       = 3'd4,
    S_PLAY_PAUSE = 3'd5
  } state_e;

  state_e            state_q;
  logic [TRK_W-1:0]  trk_q;
  logic [ADDR_W-1:0] len_q [NUM_TRACKS];
  logic [CNT_W-1:0]  init_cnt_q;
  logic init_start_q, rec_start_q, rec_pause_q, rec_stop_q;
  logic play_start_q, play_pause_q, play_stop_q, play_en_q, sram_wr_q;
`ifdef LOOP_PLAY_EN
  logic loop_q;
`endif

  logic [ADDR_W-1:0] base, rec_off, play_off, len_d;
  logic              part_full, track_end;

  // Partitions are power-of-two sized, so the base is just the track number in the top bits.
  assign base      = {trk_q, {OFF_W{1'b0}}};
  assign rec_off   = i_rec_addr - base;
  assign play_off  = i_play_addr - base;
  assign part_full = (rec_off >= PART_MAX);
  assign len_d     = part_full ? PART_MAX : rec_off;
  assign track_end = (play_off >= len_q[trk_q]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_INIT;
      trk_q        <= '0;
      init_cnt_q   <= '0;
      init_start_q <= 1'b0;
      rec_start_q  <= 1'b0;
      rec_pause_q  <= 1'b0;
      rec_stop_q   <= 1'b0;
      play_start_q <= 1'b0;
      play_pause_q <= 1'b0;
      play_stop_q  <= 1'b0;
      play_en_q    <= 1'b0;
      sram_wr_q    <= 1'b0;
`ifdef LOOP_PLAY_EN
      loop_q       <= 1'b0;
`endif
      for (int i = 0; i < NUM_TRACKS; i++) len_q[i] <= '0;
    end else begin
      rec_start_q  <= 1'b0;
      rec_pause_q  <= 1'b0;
      rec_stop_q   <= 1'b0;
      play_start_q <= 1'b0;
      play_pause_q <= 1'b0;
      play_stop_q  <= 1'b0;
      sram_wr_q    <= 1'b0;
      // The init hold runs from reset release regardless of when the codec reports done.
      if (init_cnt_q < CNT_W'(INIT_HOLD)) init_cnt_q <= init_cnt_q + CNT_W'(1);
      init_start_q <= (init_cnt_q < CNT_W'(INIT_HOLD));

      case (state_q)
        S_INIT: if (i_init_done) state_q <= S_IDLE;
        S_IDLE: begin
          if (i_key_rec) begin
            state_q     <= S_RECD;
            trk_q       <= i_track_sel;
            rec_start_q <= 1'b1;
            sram_wr_q   <= 1'b1;
          end else if (i_key_play && (len_q[i_track_sel] != '0)) begin
            state_q      <= S_PLAY;
            trk_q        <= i_track_sel;
            play_start_q <= 1'b1;
            play_en_q    <= 1'b1;
          end
        end
        S_RECD: begin
          sram_wr_q <= 1'b1;
          if (i_key_stop || part_full) begin
            state_q      <= S_IDLE;
            rec_stop_q   <= 1'b1;
            sram_wr_q    <= 1'b0;
            len_q[trk_q] <= len_d;
          end else if (i_key_rec) begin
            state_q     <= S_RECD_PAUSE;
            rec_pause_q <= 1'b1;
            sram_wr_q   <= 1'b0;
          end
        end
        S_RECD_PAUSE: begin
          if (i_key_stop) begin
            state_q      <= S_IDLE;
            rec_stop_q   <= 1'b1;
            len_q[trk_q] <= len_d;
          end else if (i_key_rec) begin
            state_q     <= S_RECD;
            rec_start_q <= 1'b1;
            sram_wr_q   <= 1'b1;
          end
        end
        S_PLAY: begin
`ifdef LOOP_PLAY_EN
          // Second cycle of a loop restart: the end condition is not looked at here.
          if (loop_q) begin
            loop_q <= 1'b0;
            if (i_key_stop) begin
              state_q     <= S_IDLE;
              play_stop_q <= 1'b1;
              play_en_q   <= 1'b0;
            end else begin
              play_start_q <= 1'b1;
            end
          end else
`endif
          if (i_key_stop) begin
            state_q     <= S_IDLE;
            play_stop_q <= 1'b1;
            play_en_q   <= 1'b0;
          end else if (track_end) begin
            play_stop_q <= 1'b1;
`ifdef LOOP_PLAY_EN
            loop_q      <= 1'b1;
`else
            state_q     <= S_IDLE;
            play_en_q   <= 1'b0;
`endif
          end else if (i_key_play) begin
            state_q      <= S_PLAY_PAUSE;
            play_pause_q <= 1'b1;
            play_en_q    <= 1'b0;
          end
        end
        S_PLAY_PAUSE: begin
          if (i_key_stop) begin
            state_q     <= S_IDLE;
            play_stop_q <= 1'b1;
            play_en_q   <= 1'b0;
          end else if (i_key_play) begin
            state_q      <= S_PLAY;
            play_start_q <= 1'b1;
            play_en_q    <= 1'b1;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          play_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_init_start = init_start_q;
  assign o_rec_start  = rec_start_q;
  assign o_rec_pause  = rec_pause_q;
  assign o_rec_stop   = rec_stop_q;
  assign o_play_start = play_start_q;
  assign o_play_pause = play_pause_q;
  assign o_play_stop  = play_stop_q;
  assign o_play_en    = play_en_q;
  assign o_sram_wr    = sram_wr_q;
  assign o_base_addr  = base;
  assign o_state      = state_q;
endmodule

// File: tb/tb_multitrack_rec_ctrl.sv
// Directed and randomized bench for multitrack_rec_ctrl against a per-cycle behavioural model.
module tb_multitrack_rec_ctrl;
  localparam int INIT_HOLD = 2048;
  localparam int PART      = 1 << 18;
  localparam int MASK      = (1 << 20) - 1;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        key_rec = 1'b0, key_play = 1'b0, key_stop = 1'b0, init_done = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [19:0] rec_addr = '0, play_addr = '0;
  logic        init_start, rec_start, rec_pause, rec_stop;
  logic        play_start, play_pause, play_stop, play_en, sram_wr;
  logic [19:0] base_addr;
  logic [2:0]  state;

  int total = 0, bad = 0;

  // Reference model: spec state codes, per-track lengths, expected pulses.
  int m_state, m_trk, m_edges;
  int m_len [4];
  bit m_en, m_loop, e_rs, e_rp, e_rt, e_ps, e_pp, e_pt;

  multitrack_rec_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_key_rec(key_rec), .i_key_play(key_play),
    .i_key_stop(key_stop), .i_track_sel(sel), .i_init_done(init_done),
    .i_rec_addr(rec_addr), .i_play_addr(play_addr), .o_init_start(init_start),
    .o_rec_start(rec_start), .o_rec_pause(rec_pause), .o_rec_stop(rec_stop),
    .o_play_start(play_start), .o_play_pause(play_pause), .o_play_stop(play_stop),
    .o_play_en(play_en), .o_sram_wr(sram_wr), .o_base_addr(base_addr), .o_state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_state));
    chk("init_start", 32'(init_start), 32'((m_edges >= 1 && m_edges <= INIT_HOLD) ? 1 : 0));
    chk("rec_start", 32'(rec_start), 32'(e_rs));
    chk("rec_pause", 32'(rec_pause), 32'(e_rp));
    chk("rec_stop", 32'(rec_stop), 32'(e_rt));
    chk("play_start", 32'(play_start), 32'(e_ps));
    chk("play_pause", 32'(play_pause), 32'(e_pp));
    chk("play_stop", 32'(play_stop), 32'(e_pt));
    chk("play_en", 32'(play_en), 32'(m_en));
    chk("sram_wr", 32'(sram_wr), 32'((m_state == 2) ? 1 : 0));
    chk("base_addr", 32'(base_addr), 32'(m_trk * PART));
  endtask

  task automatic model_reset();
    m_state = 0; m_trk = 0; m_edges = 0; m_en = 0; m_loop = 0;
    {e_rs, e_rp, e_rt, e_ps, e_pp, e_pt} = '0;
    for (int i = 0; i < 4; i++) m_len[i] = 0;
  endtask

  task automatic end_record(input int off);
    e_rt = 1;
    m_len[m_trk] = (off >= PART - 1) ? PART - 1 : off;
    m_state = 1;
  endtask

  task automatic model_step();
    int base, roff, poff;
    m_edges++;
    {e_rs, e_rp, e_rt, e_ps, e_pp, e_pt} = '0;
    base = m_trk * PART;
    roff = (int'(rec_addr) - base) & MASK;
    poff = (int'(play_addr) - base) & MASK;
    case (m_state)
      0: if (init_done) m_state = 1;
      1: if (key_rec) begin
           m_trk = int'(sel); m_state = 2; e_rs = 1;
         end else if (key_play && m_len[int'(sel)] != 0) begin
           m_trk = int'(sel); m_state = 4; e_ps = 1; m_en = 1;
         end
      2: if (key_stop || roff >= PART - 1) end_record(roff);
         else if (key_rec) begin m_state = 3; e_rp = 1; end
      3: if (key_stop) end_record(roff);
         else if (key_rec) begin m_state = 2; e_rs = 1; end
      4: if (m_loop) begin
           m_loop = 0;
           if (key_stop) begin e_pt = 1; m_en = 0; m_state = 1; end
           else e_ps = 1;
         end else if (key_stop) begin
           e_pt = 1; m_en = 0; m_state = 1;
         end else if (poff >= m_len[m_trk]) begin
           e_pt = 1;
`ifdef LOOP_PLAY_EN
           m_loop = 1;
`else
           m_en = 0; m_state = 1;
`endif
         end else if (key_play) begin
           m_state = 5; e_pp = 1; m_en = 0;
         end
      5: if (key_stop) begin e_pt = 1; m_state = 1; end
         else if (key_play) begin e_ps = 1; m_en = 1; m_state = 4; end
      default: m_state = 1;
    endcase
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    key_rec = 1'b0; key_play = 1'b0; key_stop = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_rec = 1'b0; key_play = 1'b0; key_stop = 1'b0;
    #2;
    model_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_inputs();
    int r, k, base, off, len;
    r = int'($urandom_range(0, 99));
    key_rec  = (r < 10);
    key_play = (r >= 10 && r < 22);
    key_stop = (r >= 22 && r < 27);
    if ($urandom_range(0, 24) == 0) {key_rec, key_play, key_stop} = 3'($urandom);
    sel = 2'($urandom);
    base = m_trk * PART;
    k = int'($urandom_range(0, 9));
    if (k == 0) off = PART - 1;
    else if (k == 1) off = PART - 2;
    else if (k == 2) off = int'($urandom) & MASK;
    else off = int'($urandom_range(0, 4095));
    rec_addr = 20'((base + off) & MASK);
    len = m_len[m_trk];
    k = int'($urandom_range(0, 9));
    if (k == 0) off = len;
    else if (k == 1) off = len + 1;
    else if (k == 2) off = len - 1;
    else off = int'($urandom_range(0, len));
    play_addr = 20'((base + off) & MASK);
  endtask

  initial begin
    // T1: init hold and init_done handshake; keys ignored during INIT.
    do_reset();
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) key_rec = 1'b1;
      if (c == 7) begin key_play = 1'b1; key_stop = 1'b1; end
      cycle();
    end
    chk("T1 still INIT", 32'(state), 32'd0);
    init_done = 1'b1;
    cycle();
    chk("T1 IDLE at 11", 32'(state), 32'd1);
    while (m_edges < INIT_HOLD) cycle();
    chk("T1 init_start last", 32'(init_start), 32'd1);
    cycle();
    chk("T1 init_start off", 32'(init_start), 32'd0);

    // T2: record track 2, stop at 0x80100.
    sel = 2'd2; rec_addr = 20'h80000; key_rec = 1'b1; cycle();
    chk("T2 rec_start", 32'(rec_start), 32'd1);
    chk("T2 base", 32'(base_addr), 32'h80000);
    chk("T2 sram_wr", 32'(sram_wr), 32'd1);
    rec_addr = 20'h80050; cycle();
    rec_addr = 20'h80100; key_stop = 1'b1; cycle();
    chk("T2 rec_stop", 32'(rec_stop), 32'd1);
    chk("T2 IDLE", 32'(state), 32'd1);

    // T3: record track 1 until the partition fills.
    sel = 2'd1; rec_addr = 20'h40000; key_rec = 1'b1; cycle();
    rec_addr = 20'h7FFFE; cycle();
    chk("T3 not full", 32'(rec_stop), 32'd0);
    rec_addr = 20'h7FFFF; cycle();
    chk("T3 auto stop", 32'(rec_stop), 32'd1);
    chk("T3 IDLE", 32'(state), 32'd1);

    // T4: empty track ignored; track 2 ends at offset 0x100.
    sel = 2'd3; key_play = 1'b1; cycle();
    chk("T4 empty ignored", 32'(state), 32'd1);
    sel = 2'd2; play_addr = 20'h80000; key_play = 1'b1; cycle();
    chk("T4 play_start", 32'(play_start), 32'd1);
    chk("T4 play_en", 32'(play_en), 32'd1);
    play_addr = 20'h800FF; cycle();
    chk("T4 before end", 32'(play_stop), 32'd0);
    play_addr = 20'h80100; cycle();
    chk("T4 end stop", 32'(play_stop), 32'd1);
`ifdef LOOP_PLAY_EN
    chk("T5 stays PLAY", 32'(state), 32'd4);
    cycle();
    chk("T5 restart", 32'(play_start), 32'd1);
    chk("T5 play_en", 32'(play_en), 32'd1);
    key_stop = 1'b1; cycle();
`else
    chk("T4 IDLE", 32'(state), 32'd1);
`endif
    // Track 1 should hold the full-partition length.
    sel = 2'd1; play_addr = 20'h7FFFE; key_play = 1'b1; cycle();
    cycle();
    chk("T3 len not ended", 32'(play_stop), 32'd0);
    play_addr = 20'h7FFFF; cycle();
    chk("T3 len end", 32'(play_stop), 32'd1);
    key_stop = 1'b1; cycle();
    cycle();

    // T6: rec+stop together in RECD; pause path; reset during PLAY.
    sel = 2'd0; rec_addr = 20'h00010; key_rec = 1'b1; cycle();
    rec_addr = 20'h00020; key_rec = 1'b1; key_stop = 1'b1; cycle();
    chk("T6 stop wins", 32'(rec_stop), 32'd1);
    chk("T6 no pause", 32'(rec_pause), 32'd0);
    sel = 2'd3; rec_addr = 20'hC0000; key_rec = 1'b1; cycle();
    rec_addr = 20'hC0040; key_rec = 1'b1; cycle();
    chk("T6 paused", 32'(state), 32'd3);
    key_rec = 1'b1; cycle();
    rec_addr = 20'hC0080; key_stop = 1'b1; cycle();
    sel = 2'd2; play_addr = 20'h80000; key_play = 1'b1; cycle();
    cycle();
    chk("T6 in PLAY", 32'(state), 32'd4);
    do_reset();
    chk("T6 reset state", 32'(state), 32'd0);
    chk("T6 reset play_en", 32'(play_en), 32'd0);
    cycle();
    sel = 2'd2; key_play = 1'b1; cycle();
    chk("T6 len cleared", 32'(state), 32'd1);
    sel = 2'd0; key_play = 1'b1; cycle();

    // Randomized run against the model.
    repeat (4000) begin
      rand_inputs();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
